forward_net: RTL and testbench

- Parametrised operand bypass network for the in-order pipeline; successor to the two-port fixed EX/MEM forwarder.
- Compares NUM_RD decode-stage read addresses against NUM_SRC in-flight writeback sources, youngest first.
- Registers the selected data into the ID/EX boundary.
- Raises a combinational stall when the winning source's data is not yet available (load in EX, multi-cycle result).

---
 rtl/forward_net.sv | 106 ++++++++++
 tb/tb_forward_net.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/forward_net.sv
// Operand bypass network: matches decode read ports against in-flight writeback
// sources (youngest first), registers the bypass into ID/EX and raises a load-use stall.
// Optional event counters are enabled with `define FORWARD_NET_STATS_EN.
module forward_net #(
  parameter int NUM_RD   = 2,
  parameter int NUM_SRC  = 3,
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      flush,
  input  logic                      id_stall,
  input  logic                      ex_stall,
  input  logic [NUM_RD*ADDR_W-1:0]  rd_addr,
  input  logic [NUM_SRC-1:0]        src_we,
  input  logic [NUM_SRC*ADDR_W-1:0] src_waddr,
  input  logic [NUM_SRC*DATA_W-1:0] src_wdata,
  input  logic [NUM_SRC-1:0]        src_ready,
  output logic [NUM_RD-1:0]         fwd_sel_r,
  output logic [NUM_RD*DATA_W-1:0]  fwd_data_r,
  output logic                      stall_req
`ifdef FORWARD_NET_STATS_EN
  ,
  output logic [31:0]               fwd_hit_cnt,
  output logic [31:0]               ld_stall_cnt
`endif
);

  typedef enum logic [1:0] {
    UPD_CLEAR,
    UPD_LOAD,
    UPD_HOLD
  } upd_e;

  logic [NUM_RD-1:0]        sel;
  logic [NUM_RD*DATA_W-1:0] data;
  logic [NUM_RD-1:0]        pend;
  upd_e                     upd;

  // Sources are scanned oldest to youngest so the youngest hit overwrites the rest;
  // readiness is taken from that winner only, older sources are never consulted.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    sel  = '0;
    data = '0;
    pend = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      for (int s = NUM_SRC - 1; s >= 0; s--) begin
        if (src_we[s] &&
            (src_waddr[s*ADDR_W +: ADDR_W] == rd_addr[p*ADDR_W +: ADDR_W]) &&
            !(ZERO_REG && (rd_addr[p*ADDR_W +: ADDR_W] == '0))) begin
          sel[p]                     = 1'b1;
          data[p*DATA_W +: DATA_W]   = src_wdata[s*DATA_W +: DATA_W];
          pend[p]                    = ~src_ready[s];
        end
      end
    end
  end

  assign stall_req = |pend;

  always_comb begin
    upd = UPD_HOLD;
    if (flush)                      upd = UPD_CLEAR;
    else if (id_stall && !ex_stall) upd = UPD_CLEAR;
    else if (!id_stall)             upd = stall_req ? UPD_CLEAR : UPD_LOAD;
  end

  always_ff @(posedge clk or negedge resetn) begin
    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    if (!resetn) begin
      fwd_sel_r  <= '0;
      fwd_data_r <= '0;
    end else begin
      case (upd)
        UPD_CLEAR: begin
          fwd_sel_r  <= '0;
          fwd_data_r <= '0;
        end
        UPD_LOAD: begin
          fwd_sel_r  <= sel;
          fwd_data_r <= data;
        end
        default: ;
      endcase
    end
  end

`ifdef FORWARD_NET_STATS_EN
  // Counters saturate and ignore flush; only reset clears them.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fwd_hit_cnt  <= '0;
      ld_stall_cnt <= '0;
    end else begin
      if ((upd == UPD_LOAD) && (|sel) && (fwd_hit_cnt != 32'hFFFF_FFFF))
        fwd_hit_cnt <= fwd_hit_cnt + 32'd1;
      if (stall_req && (ld_stall_cnt != 32'hFFFF_FFFF))
        ld_stall_cnt <= ld_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_forward_net.sv
// Directed self-checking bench for forward_net at default parameters
// (2 read ports, 3 sources, 32-bit data, 5-bit addresses, zero register on).
module tb_forward_net;

  logic        clk;
  logic        resetn;
  logic        flush;
  logic        id_stall;
  logic        ex_stall;
  logic [9:0]  rd_addr;
  logic [2:0]  src_we;
  logic [14:0] src_waddr;
  logic [95:0] src_wdata;
  logic [2:0]  src_ready;
  logic [1:0]  fwd_sel_r;
  logic [63:0] fwd_data_r;
  logic        stall_req;
`ifdef FORWARD_NET_STATS_EN
  logic [31:0] fwd_hit_cnt;
  logic [31:0] ld_stall_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  forward_net dut (
    .clk        (clk),
    .resetn     (resetn),
    .flush      (flush),
    .id_stall   (id_stall),
    .ex_stall   (ex_stall),
    .rd_addr    (rd_addr),
    .src_we     (src_we),
    .src_waddr  (src_waddr),
    .src_wdata  (src_wdata),
    .src_ready  (src_ready),
    .fwd_sel_r  (fwd_sel_r),
    .fwd_data_r (fwd_data_r),
    .stall_req  (stall_req)
`ifdef FORWARD_NET_STATS_EN
    ,
    .fwd_hit_cnt  (fwd_hit_cnt),
    .ld_stall_cnt (ld_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; registered outputs are read there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int s, input logic we, input logic [4:0] a,
                         input logic [31:0] d, input logic rdy);
    src_we[s]            = we;
    src_waddr[s*5 +: 5]  = a;
    src_wdata[s*32 +: 32] = d;
    src_ready[s]         = rdy;
  endtask

  task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
    rd_addr = {a1, a0};
  endtask

  initial begin
    resetn = 1'b0; flush = 1'b0; id_stall = 1'b0; ex_stall = 1'b0;
    rd_addr = '0; src_we = '0; src_waddr = '0; src_wdata = '0; src_ready = '0;
    #3;
    check("reset_sel", 64'(fwd_sel_r), 64'h0);
    check("reset_data", fwd_data_r, 64'h0);
    check("reset_stall", 64'(stall_req), 64'h0);
    #9 resetn = 1'b1;   // released between edges
    tick();

    // EX priority on port 0; port 1 hits only the WB source
    set_rd(5'd5, 5'd3);
    set_src(0, 1'b1, 5'd5, 32'h1111, 1'b1);
    set_src(1, 1'b1, 5'd5, 32'h2222, 1'b1);
    set_src(2, 1'b1, 5'd3, 32'h3333, 1'b1);
    #1 check("prio_stall", 64'(stall_req), 64'h0);
    tick();
    check("prio_sel", 64'(fwd_sel_r), 64'h3);
    check("prio_data", fwd_data_r, {32'h3333, 32'h1111});

    // Both stages held: registers keep old value despite new source data
    id_stall = 1'b1; ex_stall = 1'b1;
    set_src(0, 1'b1, 5'd5, 32'hAAAA, 1'b1);
    tick();
    check("hold_sel", 64'(fwd_sel_r), 64'h3);
    check("hold_data", fwd_data_r, {32'h3333, 32'h1111});

    // Bubble into EX
    ex_stall = 1'b0;
    tick();
    check("bubble_sel", 64'(fwd_sel_r), 64'h0);
    check("bubble_data", fwd_data_r, 64'h0);

    // Reload
    id_stall = 1'b0;
    set_src(0, 1'b1, 5'd5, 32'h1111, 1'b1);
    tick();
    check("reload_data", fwd_data_r, {32'h3333, 32'h1111});

    // Load-use: youngest hit not ready, older ready source must be ignored
    set_rd(5'd9, 5'd8);
    set_src(0, 1'b1, 5'd8, 32'h8888, 1'b0);
    set_src(1, 1'b1, 5'd8, 32'h7777, 1'b1);
    set_src(2, 1'b0, 5'd0, 32'h0, 1'b1);
    #1 check("lu_stall", 64'(stall_req), 64'h1);
    tick();
    check("lu_clear_sel", 64'(fwd_sel_r), 64'h0);
    check("lu_clear_data", fwd_data_r, 64'h0);
    src_ready[0] = 1'b1;
    #1 check("lu_ready_stall", 64'(stall_req), 64'h0);
    tick();
    check("lu_fwd_sel", 64'(fwd_sel_r), 64'h2);
    check("lu_fwd_data", fwd_data_r, {32'h8888, 32'h0});

    // Second stall cycle while both stages held: hold the forwarded value
    id_stall = 1'b1; ex_stall = 1'b1;
    src_ready[0] = 1'b0;
    #1 check("lu2_stall", 64'(stall_req), 64'h1);
    tick();
    check("lu2_hold_data", fwd_data_r, {32'h8888, 32'h0});

    // Flush beats a would-be load
    id_stall = 1'b0; ex_stall = 1'b0; flush = 1'b1;
    src_ready[0] = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_sel", 64'(fwd_sel_r), 64'h0);
    check("flush_data", fwd_data_r, 64'h0);
`ifdef FORWARD_NET_STATS_EN
    check("cnt_hit", 64'(fwd_hit_cnt), 64'd3);
    check("cnt_stall", 64'(ld_stall_cnt), 64'd2);
`endif

    // Zero register is never forwarded, even when the writer is not ready
    set_rd(5'd0, 5'd0);
    set_src(0, 1'b1, 5'd0, 32'hDEAD, 1'b0);
    set_src(1, 1'b0, 5'd0, 32'h0, 1'b1);
    #1 check("zero_stall", 64'(stall_req), 64'h0);
    tick();
    check("zero_sel", 64'(fwd_sel_r), 64'h0);
    check("zero_data", fwd_data_r, 64'h0);

    // Both ports read the same register from the MEM source
    set_rd(5'd4, 5'd4);
    set_src(0, 1'b0, 5'd0, 32'h0, 1'b1);
    set_src(1, 1'b1, 5'd4, 32'h4444, 1'b1);
    tick();
    check("dual_sel", 64'(fwd_sel_r), 64'h3);
    check("dual_data", fwd_data_r, {32'h4444, 32'h4444});

    // Async reset between edges clears outputs immediately
    #2 resetn = 1'b0;
    #1;
    check("areset_sel", 64'(fwd_sel_r), 64'h0);
    check("areset_data", fwd_data_r, 64'h0);
`ifdef FORWARD_NET_STATS_EN
    check("areset_cnt", 64'(fwd_hit_cnt), 64'h0);
`endif
    #2 resetn = 1'b1;
    tick();
    check("post_reset_load", fwd_data_r, {32'h4444, 32'h4444});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
